fifo_drain_ctrl: RTL and testbench

Read-side controller for the parameterised FIFO memory. It issues `fifo_rd` whenever the FIFO holds data and the downstream consumer has room, absorbs the FIFO's one-cycle read latency in a 2-entry skid buffer, and presents words downstream on a valid/ready handshake. It also counts delivered words and latches the FIFO `error` flag into a sticky halt state. It sits between the FIFO output and the next pipeline stage, taking the place of the bench-driven `fifo_rd`.

---
 rtl/fifo_drain_pkg.sv | 5 +
 rtl/drain_skid_buf.sv | 28 ++
 rtl/fifo_drain_ctrl.sv | 58 +++++
 tb/tb_fifo_drain_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg: shared state encoding and skid depth for the FIFO drain controller
package fifo_drain_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, HALT = 2'd2} state_t;
  localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/drain_skid_buf.sv
// drain_skid_buf: 2-entry in-order buffer absorbing the FIFO read latency
module drain_skid_buf #(
  parameter int WORD_SIZE = 6
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WORD_SIZE-1:0] din,
  output logic [1:0]           occ,
  output logic [WORD_SIZE-1:0] head,
  output logic                 not_empty
);
  logic [WORD_SIZE-1:0] tail;
  assign not_empty = occ != 2'd0;
  always_ff @(posedge clk)
    if (!reset_L) begin
      occ  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      occ <= occ + 2'(push) - 2'(pop);
      if (pop) head <= (push && occ == 2'd1) ? din : tail;
      else if (push && occ == 2'd0) head <= din;
      // tail loads on a fill from one, or on a simultaneous pop and push when full
      if (push && (occ == 2'd2 ? pop : (occ == 2'd1 && !pop))) tail <= din;
    end
endmodule

// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: issues FIFO reads, buffers read data, delivers on valid/ready
module fifo_drain_ctrl
  import fifo_drain_pkg::*;
#(
  parameter int WORD_SIZE = 6,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 enable,
  input  logic [WORD_SIZE-1:0] fifo_data_out,
  input  logic                 fifo_empty,
  input  logic                 almost_empty,
  input  logic                 error,
  output logic                 fifo_rd,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 low_water,
  output logic [CNT_W-1:0]     word_count,
  output logic                 halted
);
  state_t     state;
  logic       pend, pop;
  logic [1:0] occ;
  logic [2:0] load;
  assign pop  = valid_out & ready_in;
  assign load = 3'(occ) + 3'(pend) - 3'(pop);
  // gated by reset_L so no read escapes while a mid-operation reset is pending
  assign fifo_rd = reset_L && state == ACTIVE && enable && !fifo_empty && !error
                   && load < 3'(SKID_DEPTH);
  drain_skid_buf #(.WORD_SIZE(WORD_SIZE)) u_skid (
    .clk       (clk),
    .reset_L   (reset_L),
    .push      (pend),
    .pop       (pop),
    .din       (fifo_data_out),
    .occ       (occ),
    .head      (data_out),
    .not_empty (valid_out)
  );
  always_ff @(posedge clk)
    if (!reset_L) begin
      state      <= IDLE;
      pend       <= 1'b0;
      word_count <= '0;
      halted     <= 1'b0;
      low_water  <= 1'b0;
    end else begin
      state      <= error ? HALT :
                    (state == IDLE && enable) ? ACTIVE :
                    (state == ACTIVE && !enable) ? IDLE : state;
      pend       <= fifo_rd;
      word_count <= word_count + CNT_W'(pop);
      halted     <= halted | error;
      low_water  <= almost_empty;
    end
endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb_fifo_drain_ctrl: directed vectors with hand-computed expectations for fifo_drain_ctrl
module tb_fifo_drain_ctrl;
  logic       clk = 1'b0;
  logic       reset_L, enable, almost_empty, error, ready_in;
  logic [5:0] fifo_data_out;
  logic       fifo_empty, fifo_rd, valid_out, low_water, halted;
  logic [5:0] data_out;
  logic [7:0] word_count;
  logic [5:0] mem [512];
  int         wp = 0, rp = 0;
  int         n_vec = 0, n_bad = 0;

  fifo_drain_ctrl #(.WORD_SIZE(6), .CNT_W(8)) dut (
    .clk           (clk),
    .reset_L       (reset_L),
    .enable        (enable),
    .fifo_data_out (fifo_data_out),
    .fifo_empty    (fifo_empty),
    .almost_empty  (almost_empty),
    .error         (error),
    .fifo_rd       (fifo_rd),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .low_water     (low_water),
    .word_count    (word_count),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  // FIFO with one-cycle read latency
  assign fifo_empty = (wp == rp);
  always @(posedge clk)
    if (fifo_rd) begin
      fifo_data_out <= mem[rp];
      rp <= rp + 1;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) chk("rd_while_empty", {31'b0, fifo_rd & fifo_empty}, 0);

  task automatic load(input logic [5:0] w);
    mem[wp] = w;
    wp++;
  endtask

  // drive one cycle's inputs, check at the falling edge, return at posedge+1
  task automatic step(input logic en, input logic rdy, input logic err,
                      input logic xrd, input logic xv, input logic xh, input logic [5:0] xd);
    enable = en; ready_in = rdy; error = err;
    @(negedge clk);
    chk("fifo_rd", fifo_rd, xrd);
    chk("valid_out", valid_out, xv);
    chk("halted", halted, xh);
    if (xv) chk("data_out", data_out, xd);
    @(posedge clk); #1;
  endtask

  initial begin
    int k;
    reset_L = 0; enable = 1; ready_in = 1; error = 0; almost_empty = 0;
    load(6'h0A); load(6'h15); load(6'h2C); load(6'h3F);
    repeat (5) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_fifo_rd", fifo_rd, 0);
    end
    chk("rst_data", data_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_count", word_count, 0);
    chk("rst_halted", halted, 0);
    chk("rst_low_water", low_water, 0);
    @(posedge clk); #1;
    reset_L = 1;
    // streaming with ready_in high
    step(1,1,0, 0,0,0, 0);
    step(1,1,0, 1,0,0, 0);
    step(1,1,0, 1,0,0, 0);
    step(1,1,0, 1,1,0, 6'h0A);
    step(1,1,0, 1,1,0, 6'h15);
    step(1,1,0, 0,1,0, 6'h2C);
    step(1,1,0, 0,1,0, 6'h3F);
    step(1,1,0, 0,0,0, 0);
    chk("count_stream", word_count, 4);
    // backpressure: two reads outstanding, head held
    ready_in = 0;
    load(6'h0A); load(6'h15); load(6'h2C); load(6'h3F);
    step(1,0,0, 1,0,0, 0);
    step(1,0,0, 1,0,0, 0);
    step(1,0,0, 0,1,0, 6'h0A);
    step(1,0,0, 0,1,0, 6'h0A);
    step(1,0,0, 0,1,0, 6'h0A);
    step(1,0,0, 0,1,0, 6'h0A);
    step(1,1,0, 1,1,0, 6'h0A);
    step(1,1,0, 1,1,0, 6'h15);
    step(1,1,0, 0,1,0, 6'h2C);
    step(1,1,0, 0,1,0, 6'h3F);
    step(1,1,0, 0,0,0, 0);
    chk("count_bp", word_count, 8);
    // enable drops after a read; in-flight word still delivered, then resume
    load(6'h01); load(6'h02); load(6'h03);
    step(1,1,0, 1,0,0, 0);
    step(0,1,0, 0,0,0, 0);
    step(0,1,0, 0,1,0, 6'h01);
    step(0,1,0, 0,0,0, 0);
    step(0,1,0, 0,0,0, 0);
    step(1,1,0, 0,0,0, 0);
    step(1,1,0, 1,0,0, 0);
    step(1,1,0, 1,0,0, 0);
    step(1,1,0, 0,1,0, 6'h02);
    step(1,1,0, 0,1,0, 6'h03);
    step(1,1,0, 0,0,0, 0);
    chk("count_enable", word_count, 11);
    // low_water lags almost_empty by one cycle
    almost_empty = 1;
    @(negedge clk); chk("low_water_lag", low_water, 0);
    @(negedge clk); chk("low_water_set", low_water, 1);
    almost_empty = 0;
    @(posedge clk); #1;
    // error pulse mid-stream
    load(6'h11); load(6'h22); load(6'h33); load(6'h04);
    step(1,1,0, 1,0,0, 0);
    step(1,1,0, 1,0,0, 0);
    step(1,1,1, 0,1,0, 6'h11);
    step(1,1,0, 0,1,1, 6'h22);
    step(1,1,0, 0,0,1, 0);
    step(1,1,0, 0,0,1, 0);
    step(1,1,0, 0,0,1, 0);
    chk("count_halt", word_count, 13);
    wp = rp;
    reset_L = 0;
    @(negedge clk);
    chk("halt_before_rst", halted, 1);
    @(posedge clk); #1;
    reset_L = 1;
    @(negedge clk);
    chk("halt_cleared", halted, 0);
    chk("count_cleared", word_count, 0);
    @(posedge clk); #1;
    // 257 words: counter wraps to 1
    for (int i = 0; i < 257; i++) load(6'(i));
    k = 0;
    for (int c = 0; c < 400 && k < 257; c++) begin
      @(negedge clk);
      if (valid_out && ready_in) begin
        chk("wrap_data", data_out, k & 63);
        k++;
      end
    end
    chk("wrap_words", k, 257);
    @(negedge clk);
    chk("wrap_count", word_count, 1);
    chk("wrap_drained", valid_out, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
